mem_port_arbiter: RTL and testbench

//   Shares one single-ported unified memory between the IF stage (instruction fetch)
//   and the MEM stage (LWD/SWD data access) of the pipelined CPU.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (I) and data
//   load/store (D). Each granted access holds its strobe for LATENCY cycles,
//   then the owner receives a one-cycle registered ready pulse. Data wins over
//   fetch, but after STARVE_LIMIT consecutive data grants that beat a waiting
//   fetch, the fetch is forced through.
// Ports
//   clk, reset_n            clock; asynchronous reset, active-high despite the name
//   i_req/i_addr            fetch request, held until i_ready
//   i_ready/i_rdata         fetch done pulse; fetched word (held)
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store), held until d_ready
//   d_ready/d_rdata         data done pulse; load word (held)
//   m_rd/m_wr/m_addr/m_wdata/m_rdata  memory side
//   busy                    arbiter not idle
module mem_port_arbiter #(
   parameter int unsigned WORD         = 16,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_req,
   input  logic [WORD-1:0] i_addr,
   output logic            i_ready,
   output logic [WORD-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [WORD-1:0] d_addr,
   input  logic [WORD-1:0] d_wdata,
   output logic            d_ready,
   output logic [WORD-1:0] d_rdata,
   output logic            m_rd,
   output logic            m_wr,
   output logic [WORD-1:0] m_addr,
   output logic [WORD-1:0] m_wdata,
   input  logic [WORD-1:0] m_rdata,
   output logic            busy
);

   localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);
   localparam logic [StW-1:0]  StMax   = StW'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [StW-1:0]  starve_q, starve_d;
   logic            owner_q, owner_d;   // 1 = data port owns the access
   logic            we_q, we_d;
   logic [WORD-1:0] addr_q, addr_d;
   logic [WORD-1:0] wdata_q, wdata_d;
   logic [WORD-1:0] i_rdata_q, i_rdata_d;
   logic [WORD-1:0] d_rdata_q, d_rdata_d;
   logic            i_ready_q, i_ready_d;
   logic            d_ready_q, d_ready_d;
   logic            grant_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      starve_d  = starve_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
      // Data wins unless a waiting fetch has been starved to the limit.
      grant_d   = d_req & ~(i_req & (starve_q == StMax));

      case (state_q)
         StIdle: begin
            if (i_req || d_req) begin
               state_d = StAccess;
               cnt_d   = CntInit;
               owner_d = grant_d;
               if (grant_d) begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  if (i_req && (starve_q != StMax)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end else begin
                  we_d     = 1'b0;
                  addr_d   = i_addr;
                  starve_d = '0;
               end
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               // Ready is set here so it is a flop output during StDone.
               if (owner_q) begin
                  d_ready_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = m_rdata;
                  end
               end else begin
                  i_ready_d = 1'b1;
                  i_rdata_d = m_rdata;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         starve_q  <= '0;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
      end
   end

   // Fetches latch we_q=0, so every non-store access reads.
   assign m_rd    = (state_q == StAccess) & ~we_q;
   assign m_wr    = (state_q == StAccess) & we_q;
   // addr_q/wdata_q only change on a grant, so they hold outside StAccess.
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign i_ready = i_ready_q;
   assign d_ready = d_ready_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=2 instance checked by a
// ready-driven scoreboard plus cycle-exact strobe checks, and a LATENCY=1
// instance checked directly. Memory returns m_addr ^ 16'h1224.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_ready, d_ready, m_rd, m_wr, busy;
   logic [15:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   logic        i_req1, d_req1, d_we1;
   logic [15:0] i_addr1, d_addr1, d_wdata1;
   logic        i_ready1, d_ready1, m_rd1, m_wr1, busy1;
   logic [15:0] i_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_i[$];
   logic [15:0] exp_d[$];
   logic [15:0] exp_order[$];   // 0 = fetch ready, 1 = data ready
   logic [15:0] last_d;
   logic [15:0] mon_e;

   assign m_rdata  = m_addr ^ 16'h1224;
   assign m_rdata1 = m_addr1 ^ 16'h1224;

   mem_port_arbiter #(.WORD(16), .LATENCY(2), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .reset_n(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy)
   );

   mem_port_arbiter #(.WORD(16), .LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
      .clk(clk), .reset_n(rst),
      .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_ready(d_ready1), .d_rdata(d_rdata1),
      .m_rd(m_rd1), .m_wr(m_wr1), .m_addr(m_addr1), .m_wdata(m_wdata1),
      .m_rdata(m_rdata1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: pops expectations whenever a ready pulse appears.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_rd && m_wr) begin
            errors++;
            $display("FAIL strobe_excl: m_rd=1 m_wr=1 at %0t", $time);
         end
         if (i_ready || d_ready) begin
            if (exp_order.size() == 0) begin
               errors++;
               $display("FAIL order: unexpected ready i=%b d=%b at %0t", i_ready, d_ready, $time);
            end else begin
               mon_e = exp_order.pop_front();
               chk_w("grant_order", {15'b0, d_ready}, mon_e);
            end
         end
         if (i_ready) begin
            if (exp_i.size() == 0) begin
               errors++;
               $display("FAIL i_ready: unexpected pulse at %0t", $time);
            end else begin
               mon_e = exp_i.pop_front();
               chk_w("i_rdata", i_rdata, mon_e);
            end
         end
         if (d_ready) begin
            if (exp_d.size() == 0) begin
               errors++;
               $display("FAIL d_ready: unexpected pulse at %0t", $time);
            end else begin
               mon_e = exp_d.pop_front();
               chk_w("d_rdata", d_rdata, mon_e);
            end
         end
      end
   end

   // One isolated access on the LATENCY=2 instance, cycle-exact.
   task automatic single(input logic isd, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata);
      if (isd) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
         if (!we) last_d = addr ^ 16'h1224;
         exp_d.push_back(last_d);
         exp_order.push_back(16'd1);
      end else begin
         i_req = 1'b1; i_addr = addr;
         exp_i.push_back(addr ^ 16'h1224);
         exp_order.push_back(16'd0);
      end
      chk_b("c0_busy", busy, 1'b0);
      for (int k = 1; k <= 2; k++) begin
         cyc();
         chk_b("acc_rd", m_rd, ~(isd & we));
         chk_b("acc_wr", m_wr, isd & we);
         chk_w("acc_addr", m_addr, addr);
         if (isd && we) chk_w("acc_wdata", m_wdata, wdata);
         chk_b("acc_busy", busy, 1'b1);
         chk_b("acc_noready", isd ? d_ready : i_ready, 1'b0);
      end
      cyc();
      chk_b("done_ready", isd ? d_ready : i_ready, 1'b1);
      chk_b("done_other", isd ? i_ready : d_ready, 1'b0);
      chk_b("done_rd", m_rd, 1'b0);
      chk_b("done_wr", m_wr, 1'b0);
      i_req = 1'b0; d_req = 1'b0;
      cyc();
      chk_b("after_ready", isd ? d_ready : i_ready, 1'b0);
      chk_b("after_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int budget;
      rst = 1'b1;
      i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
      last_d = 16'h0000;
      repeat (3) cyc();
      chk_b("rst_i_ready", i_ready, 1'b0);
      chk_b("rst_d_ready", d_ready, 1'b0);
      chk_b("rst_m_rd", m_rd, 1'b0);
      chk_b("rst_m_wr", m_wr, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_w("rst_m_addr", m_addr, 16'h0000);
      chk_w("rst_i_rdata", i_rdata, 16'h0000);
      chk_w("rst_d_rdata", d_rdata, 16'h0000);
      chk_b("rst_busy1", busy1, 1'b0);
      rst = 1'b0;
      cyc();

      // Fetch at 0x0010 returns 0x1234.
      single(1'b0, 1'b0, 16'h0010, 16'h0000);
      // Store leaves d_rdata at its reset value.
      single(1'b1, 1'b1, 16'h0200, 16'hBEEF);
      chk_w("store_d_rdata", d_rdata, 16'h0000);

      // Simultaneous load + fetch: data first, fetch granted at cycle 4.
      i_req = 1'b1; i_addr = 16'h0020;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
      last_d = 16'h1324;
      exp_d.push_back(16'h1324); exp_order.push_back(16'd1);
      exp_i.push_back(16'h1204); exp_order.push_back(16'd0);
      cyc(); chk_w("both_c1_addr", m_addr, 16'h0100); chk_b("both_c1_rd", m_rd, 1'b1);
      cyc(); chk_b("both_c2_ready", d_ready, 1'b0);
      cyc(); chk_b("both_c3_dready", d_ready, 1'b1); chk_b("both_c3_iready", i_ready, 1'b0);
      d_req = 1'b0;
      cyc(); chk_b("both_c4_busy", busy, 1'b0);
      cyc(); chk_w("both_c5_addr", m_addr, 16'h0020); chk_b("both_c5_rd", m_rd, 1'b1);
      cyc(); chk_b("both_c6_iready", i_ready, 1'b0);
      cyc(); chk_b("both_c7_iready", i_ready, 1'b1);
      i_req = 1'b0;
      cyc();

      // Starvation: both held, expect D,D,D,D,I,D.
      i_req = 1'b1; i_addr = 16'h0030;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
      last_d = 16'h1124;
      for (int k = 0; k < 6; k++) begin
         exp_order.push_back((k == 4) ? 16'd0 : 16'd1);
         if (k == 4) exp_i.push_back(16'h1214);
         else        exp_d.push_back(16'h1124);
      end
      n = 0;
      budget = 60;
      while (n < 6 && budget > 0) begin
         cyc();
         if (i_ready || d_ready) n++;
         budget--;
      end
      chk_w("starve_pulses", 16'(n), 16'd6);
      i_req = 1'b0; d_req = 1'b0;
      cyc(); chk_b("starve_idle", busy, 1'b0);

      // Reset during the first access cycle of a fetch.
      i_req = 1'b1; i_addr = 16'h0040;
      exp_i.push_back(16'h1264); exp_order.push_back(16'd0);
      cyc(); chk_b("rstmid_c1_rd", m_rd, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_b("rstmid_rd", m_rd, 1'b0);
      chk_b("rstmid_busy", busy, 1'b0);
      chk_b("rstmid_iready", i_ready, 1'b0);
      cyc();
      chk_b("rstmid_hold_busy", busy, 1'b0);
      rst = 1'b0;
      cyc(); chk_b("rstmid_s1_rd", m_rd, 1'b1); chk_w("rstmid_s1_addr", m_addr, 16'h0040);
      cyc(); chk_b("rstmid_s2_iready", i_ready, 1'b0);
      cyc(); chk_b("rstmid_s3_iready", i_ready, 1'b1);
      i_req = 1'b0;
      cyc(); chk_b("rstmid_idle", busy, 1'b0);

      // LATENCY=1 instance: back-to-back loads every 3 cycles.
      d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 16'h0400;
      chk_b("l1_c0_busy", busy1, 1'b0);
      cyc(); chk_b("l1_c1_rd", m_rd1, 1'b1); chk_b("l1_c1_ready", d_ready1, 1'b0);
      cyc(); chk_b("l1_c2_rd", m_rd1, 1'b0); chk_b("l1_c2_ready", d_ready1, 1'b1);
      chk_w("l1_c2_rdata", d_rdata1, 16'h1624);
      cyc(); chk_b("l1_c3_busy", busy1, 1'b0); chk_b("l1_c3_ready", d_ready1, 1'b0);
      d_addr1 = 16'h0401;
      cyc(); chk_b("l1_c4_rd", m_rd1, 1'b1); chk_w("l1_c4_addr", m_addr1, 16'h0401);
      cyc(); chk_b("l1_c5_ready", d_ready1, 1'b1); chk_w("l1_c5_rdata", d_rdata1, 16'h1625);
      d_req1 = 1'b0;
      cyc(); chk_b("l1_idle", busy1, 1'b0);

      cyc();
      chk_w("sb_i_empty", 16'(exp_i.size()), 16'd0);
      chk_w("sb_d_empty", 16'(exp_d.size()), 16'd0);
      chk_w("sb_order_empty", 16'(exp_order.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
